// File: rtl/arith_decode_pkg.sv
// arith_decode_pkg: shared encodings and bundle types for the arith decode stage.
package arith_decode_pkg;
  localparam int XLEN = 32;
  localparam logic [9:0] OP0 = 10'd1 << 0;
  localparam logic [9:0] OP1 = 10'd1 << 1;
  localparam logic [9:0] OP2 = 10'd1 << 2;
  localparam logic [9:0] OP3 = 10'd1 << 3;
  localparam logic [9:0] OP4 = 10'd1 << 4;
  localparam logic [9:0] OP5 = 10'd1 << 5;
  localparam logic [9:0] OP6 = 10'd1 << 6;
  localparam logic [9:0] OP7 = 10'd1 << 7;
  localparam logic [9:0] OP8 = 10'd1 << 8;
  localparam logic [9:0] OP9 = 10'd1 << 9;
  localparam logic [1:0] RN = 2'd0;
  localparam logic [1:0] RR = 2'd1;
  localparam logic [1:0] RI = 2'd2;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  typedef struct packed {
    logic [9:0]      aop;
    logic [1:0]      rr_ri;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            is_alu;
    logic            illegal;
  } dec_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    dec_t            dec;
  } bundle_t;
  localparam bundle_t BUNDLE_RST = '{pc: '0, dec: '{aop: OP0, rr_ri: RN, rs1: '0, rs2: '0, rd: '0,
                                                   imm: '0, is_alu: 1'b0, illegal: 1'b0}};
endpackage

// File: rtl/arith_decode_comb.sv
// arith_decode_comb: pure RV32I OP/OP-IMM field decode into the arith control bundle.
module arith_decode_comb
  import arith_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);
  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       is_op;
  logic       is_imm;
  logic       shift;
  logic       alt;
  logic       bad;
  logic [3:0] idx;
  always_comb begin
    opc = instr_i[6:0];
    f3 = instr_i[14:12];
    f7 = instr_i[31:25];
    is_op = opc == OPC_OP;
    is_imm = opc == OPC_OPIMM;
    shift = f3 == 3'd1 || f3 == 3'd5;
    alt = f7 == F7_ALT;
    bad = is_op ? f7 != '0 && !(alt && (f3 == 3'd0 || f3 == 3'd5))
                : is_imm && shift && f7 != '0 && !(alt && f3 == 3'd5);
    // ALT funct7 selects SUB (reg-reg only) or SRA/SRAI
    idx = alt && f3 == 3'd0 && is_op ? 4'd8 : alt && f3 == 3'd5 ? 4'd9 : {1'b0, f3};
    dec_o.aop = (is_op || is_imm) && !bad ? 10'd1 << idx : OP0;
    dec_o.rr_ri = is_op ? RR : is_imm ? RI : RN;
    dec_o.rs1 = instr_i[19:15];
    dec_o.rs2 = instr_i[24:20];
    dec_o.rd = instr_i[11:7];
    dec_o.imm = !is_imm ? '0 : shift ? {27'b0, instr_i[24:20]} : {{20{instr_i[31]}}, instr_i[31:20]};
    dec_o.is_alu = is_op || is_imm;
    dec_o.illegal = bad;
  end
endmodule

// File: rtl/arith_decode.sv
// arith_decode: registered decode stage with optional skid buffer feeding the arith unit.
module arith_decode
  import arith_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [9:0]      out_aop,
  output logic [1:0]      out_rr_ri,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_is_alu,
  output logic            out_illegal
);
  dec_t    dec;
  bundle_t in_b, out_q, out_d, skid_q, skid_d;
  logic    out_v_q, out_v_d, skid_v_q, skid_v_d, load, acc;
  arith_decode_comb u_comb (.instr_i(in_instr), .dec_o(dec));
  assign in_b = '{pc: in_pc, dec: dec};
  assign load = !out_v_q || out_ready;
  // with a skid buffer in_ready depends only on a flop, breaking the ready path
  assign in_ready = SKID ? !skid_v_q : load;
  assign acc = in_valid && in_ready;
  always_comb begin
    out_d = !load ? out_q : skid_v_q ? skid_q : acc ? in_b : out_q;
    out_v_d = !flush && (load ? skid_v_q || acc : out_v_q);
    skid_d = acc && !load ? in_b : skid_q;
    skid_v_d = !flush && SKID && !load && (skid_v_q || acc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= BUNDLE_RST;
      skid_q <= BUNDLE_RST;
      out_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_v_q <= out_v_d;
      skid_v_q <= skid_v_d;
    end
  end
  assign out_valid = out_v_q;
  assign out_pc = out_q.pc;
  assign out_aop = out_q.dec.aop;
  assign out_rr_ri = out_q.dec.rr_ri;
  assign out_rs1 = out_q.dec.rs1;
  assign out_rs2 = out_q.dec.rs2;
  assign out_rd = out_q.dec.rd;
  assign out_imm = out_q.dec.imm;
  assign out_is_alu = out_q.dec.is_alu;
  assign out_illegal = out_q.dec.illegal;
endmodule
